// File: rtl/usb_pkg.sv
// Shared definitions for the FT245 USB FIFO interface (transmit and receive sides).
package usb_pkg;

  localparam int BYTE_W  = 8;
  localparam int ENTRY_W = BYTE_W + 1;

  localparam int DEF_DEPTH     = 16;
  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_WR_CYC    = 5;
  localparam int DEF_RECOV_CYC = 8;
  localparam int DEF_SI_CYC    = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RECOV,
    SI
  } tx_state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/usb_tx_if.sv
// Producer-side byte stream into the USB transmit FIFO.
interface usb_tx_if;
  import usb_pkg::*;

  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_last;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);

endinterface

// File: rtl/usb_tx_fifo.sv
// Synchronous FIFO holding {last, data} entries; extra pointer MSB separates full from empty.
module usb_tx_fifo
  import usb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [ENTRY_W-1:0]           wdata,
  input  logic                         pop,
  output logic [ENTRY_W-1:0]           rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/usb_tx.sv
// FT245 transmit engine: buffers producer bytes and writes them to the device under TXE#.
module usb_tx
  import usb_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int WR_CYC    = DEF_WR_CYC,
  parameter int RECOV_CYC = DEF_RECOV_CYC,
  parameter int SI_CYC    = DEF_SI_CYC
) (
  input  logic                        clk,
  input  logic                        rst_n,
  usb_tx_if.slave                     bus,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_level,
  input  logic                        txe,
  input  logic                        rx_busy,
  output logic                        tx_busy,
  output logic                        wr,
  output logic [BYTE_W-1:0]           d_out,
  output logic                        d_oe,
  output logic                        si_n
);

  localparam int CNT_W = $clog2(max_of(max_of(SETUP_CYC, WR_CYC), max_of(RECOV_CYC, SI_CYC)) + 1);
  localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] WR_END    = CNT_W'(WR_CYC - 1);
  localparam logic [CNT_W-1:0] RECOV_END = CNT_W'(RECOV_CYC - 1);
  localparam logic [CNT_W-1:0] SI_END    = CNT_W'(SI_CYC - 1);

  tx_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic               last_q;
  logic               txe_meta;
  logic               txe_s;
  logic               full;
  logic               empty;
  logic               start;
  logic [ENTRY_W-1:0] head;

  usb_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.tx_valid),
    .wdata ({bus.tx_last, bus.tx_data}),
    .pop   (start),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign bus.tx_ready = !full;
  assign start        = (state == IDLE) && !empty && !txe_s && !rx_busy;
  assign tx_busy      = start || (state == SETUP) || (state == STROBE) || (state == HOLD);

  // TXE# is asynchronous; both flops reset to "device not ready".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txe_meta <= 1'b1;
      txe_s    <= 1'b1;
    end else begin
      txe_meta <= txe;
      txe_s    <= txe_meta;
    end
  end

  // Each phase counts from zero and leaves when the count reaches its length minus one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      last_q <= 1'b0;
      wr     <= 1'b0;
      d_oe   <= 1'b0;
      d_out  <= '0;
      si_n   <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            state  <= SETUP;
            d_out  <= head[BYTE_W-1:0];
            last_q <= head[BYTE_W];
            d_oe   <= 1'b1;
            wr     <= 1'b0;
          end
        end
        SETUP: begin
          if (cnt == SETUP_END) begin
            state <= STROBE;
            wr    <= 1'b1;
            cnt   <= '0;
          end
        end
        STROBE: begin
          if (cnt == WR_END) begin
            state <= HOLD;
            wr    <= 1'b0;
            cnt   <= '0;
          end
        end
        HOLD: begin
          state <= RECOV;
          d_oe  <= 1'b0;
          cnt   <= '0;
        end
        RECOV: begin
          if (cnt == RECOV_END) begin
            cnt <= '0;
            if (last_q) begin
              state <= SI;
              si_n  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        SI: begin
          if (cnt == SI_END) begin
            state <= IDLE;
            si_n  <= 1'b1;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
